// File: rtl/imem_arb.sv
// Two-port arbiter in front of a single-port synchronous instruction RAM.
// A fetch port and a loader port share the RAM; the loader can halt fetch.
//
// state  | meaning
// -------+-------------------------------------------------------------
// RUN    | both ports arbitrated round-robin on conflict
// DRAIN  | fetch blocked, waiting for any in-flight fetch to retire
// HALTED | loader owns the RAM exclusively, halt_ack asserted
module imem_arb #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          f_req,
  input  logic [31:0]   f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic          f_err,
  output logic [31:0]   f_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [31:0]   l_addr,
  input  logic [31:0]   l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic          l_err,
  output logic [31:0]   l_rdata,
  input  logic          halt_req,
  output logic          halt_ack,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  input  logic [31:0]   m_rdata
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_l_q, last_l_d;
  logic   f_rvalid_q, f_err_q, f_rd_q;
  logic   l_rvalid_q, l_err_q, l_rd_q;
  logic   f_bad, l_bad, f_ok;

  // Misaligned or beyond the RAM: granted but never reaches the RAM.
  assign f_bad = (f_addr[1:0] != 2'b00) || ((f_addr >> (AW + 2)) != 32'd0);
  assign l_bad = (l_addr[1:0] != 2'b00) || ((l_addr >> (AW + 2)) != 32'd0);

  always_comb begin
    state_d  = state_q;
    last_l_d = last_l_q;
    f_gnt    = 1'b0;
    l_gnt    = 1'b0;
    m_en     = 1'b0;
    m_we     = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    f_ok     = (state_q == S_RUN) && !halt_req;

    if (reset_n) begin
      if (f_req && f_ok && l_req) begin
        f_gnt = last_l_q;
        l_gnt = !last_l_q;
      end else begin
        f_gnt = f_req && f_ok;
        l_gnt = l_req;
      end
    end

    if (f_gnt) begin
      m_en     = !f_bad;
      m_addr   = f_addr[AW+1:2];
      last_l_d = 1'b0;
    end else if (l_gnt) begin
      m_en     = !l_bad;
      m_we     = l_we && !l_bad;
      m_addr   = l_addr[AW+1:2];
      m_wdata  = l_wdata;
      last_l_d = 1'b1;
    end

    // Fetch grants stop the cycle halt_req is seen in RUN, so by the time
    // DRAIN is reached the last fetch response has already been registered.
    case (state_q)
      S_RUN:    if (halt_req) state_d = S_DRAIN;
      S_DRAIN:  state_d = halt_req ? (f_rvalid_q ? S_DRAIN : S_HALTED) : S_RUN;
      S_HALTED: if (!halt_req) state_d = S_RUN;
      default:  state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_RUN;
      last_l_q   <= 1'b1;
      f_rvalid_q <= 1'b0;
      f_err_q    <= 1'b0;
      f_rd_q     <= 1'b0;
      l_rvalid_q <= 1'b0;
      l_err_q    <= 1'b0;
      l_rd_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_l_q   <= last_l_d;
      f_rvalid_q <= f_gnt;
      f_err_q    <= f_gnt && f_bad;
      f_rd_q     <= f_gnt && !f_bad;
      l_rvalid_q <= l_gnt;
      l_err_q    <= l_gnt && l_bad;
      l_rd_q     <= l_gnt && !l_bad && !l_we;
    end
  end

  // m_rdata is the RAM's own output register; gate it with registered flags.
  assign f_rvalid = f_rvalid_q;
  assign f_err    = f_err_q;
  assign f_rdata  = f_rd_q ? m_rdata : 32'd0;
  assign l_rvalid = l_rvalid_q;
  assign l_err    = l_err_q;
  assign l_rdata  = l_rd_q ? m_rdata : 32'd0;
  assign halt_ack = (state_q == S_HALTED);

endmodule

// File: tb/tb_imem_arb.sv
// Directed plus random bench for imem_arb against a transaction-level model
// of the arbitration, halt and error rules, with a behavioural RAM attached.
module tb_imem_arb;

  localparam int AW = 6;
  localparam int WORDS = 1 << AW;
  localparam int MD_RUN = 0, MD_DRAIN = 1, MD_HALT = 2;

  logic clk = 1'b0;
  logic reset_n;
  logic f_req, f_gnt, f_rvalid, f_err;
  logic [31:0] f_addr, f_rdata;
  logic l_req, l_we, l_gnt, l_rvalid, l_err;
  logic [31:0] l_addr, l_wdata, l_rdata;
  logic halt_req, halt_ack;
  logic m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [31:0] m_wdata, m_rdata;

  logic [31:0] mem [WORDS];
  logic [31:0] ref_mem [WORDS];

  int checks = 0;
  int errors = 0;

  int mode;
  bit last_l;
  bit efv, efe, elv, ele;
  logic [31:0] efd, eld;

  always #5 clk = ~clk;

  imem_arb #(.AW(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_err(f_err), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_err(l_err), .l_rdata(l_rdata),
    .halt_req(halt_req), .halt_ack(halt_ack),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  always @(posedge clk) begin
    if (m_en && m_we) mem[m_addr] <= m_wdata;
    if (m_en && !m_we) m_rdata <= mem[m_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 4 * WORDS);
  endfunction

  task automatic model_reset();
    mode = MD_RUN;
    last_l = 1'b1;
    {efv, efe, elv, ele} = 4'b0;
    efd = 32'd0;
    eld = 32'd0;
  endtask

  // Inputs already driven; checks grants mid-cycle, then responses after the edge.
  task automatic step();
    bit fg, lg, fok, bad, exp_en, exp_we;
    int idx;
    #2;
    fok = (mode == MD_RUN) && !halt_req;
    if (f_req && fok && l_req) begin
      fg = !last_l;
      fg = last_l;
      lg = !fg;
    end else begin
      fg = f_req && fok;
      lg = l_req;
    end
    chk("f_gnt", f_gnt, fg);
    chk("l_gnt", l_gnt, lg);
    chk("halt_ack", halt_ack, mode == MD_HALT);
    bad = fg ? addr_bad(f_addr) : addr_bad(l_addr);
    idx = fg ? int'(f_addr / 4) : int'(l_addr / 4);
    exp_en = (fg || lg) && !bad;
    exp_we = lg && l_we && !bad;
    chk("m_en", m_en, exp_en);
    chk("m_we", m_we, exp_we);
    if (exp_en) chk("m_addr", 32'(m_addr), 32'(idx));
    if (exp_we) chk("m_wdata", m_wdata, l_wdata);

    efv = fg;
    efe = fg && bad;
    efd = (fg && !bad) ? ref_mem[idx] : 32'd0;
    elv = lg;
    ele = lg && bad;
    eld = (lg && !bad && !l_we) ? ref_mem[idx] : 32'd0;
    if (exp_we) ref_mem[idx] = l_wdata;
    if (fg) last_l = 1'b0;
    if (lg) last_l = 1'b1;
    case (mode)
      MD_RUN:   if (halt_req) mode = MD_DRAIN;
      MD_DRAIN: mode = halt_req ? MD_HALT : MD_RUN;
      default:  if (!halt_req) mode = MD_RUN;
    endcase

    @(posedge clk);
    #1;
    chk("f_rvalid", f_rvalid, efv);
    chk("f_err", f_err, efe);
    chk("f_rdata", f_rdata, efd);
    chk("l_rvalid", l_rvalid, elv);
    chk("l_err", l_err, ele);
    chk("l_rdata", l_rdata, eld);
  endtask

  task automatic drive(input bit fr, input logic [31:0] fa, input bit lr, input bit we,
                       input logic [31:0] la, input logic [31:0] wd, input bit hr);
    f_req = fr; f_addr = fa; l_req = lr; l_we = we; l_addr = la; l_wdata = wd;
    halt_req = hr;
    step();
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0) return $urandom;
    if (r == 1) return 32'($urandom_range(0, WORDS - 1) << 2) | 32'd2;
    return 32'($urandom_range(0, WORDS - 1) << 2);
  endfunction

  initial begin
    bit hr;
    for (int i = 0; i < WORDS; i++) begin
      mem[i] = 32'(i);
      ref_mem[i] = 32'(i);
    end
    m_rdata = 32'd0;
    reset_n = 1'b0;
    f_req = 1'b1; f_addr = 32'd0; l_req = 1'b1; l_we = 1'b1; l_addr = 32'd0;
    l_wdata = 32'd0; halt_req = 1'b0;
    model_reset();
    #12;
    chk("rst_f_gnt", f_gnt, 1'b0);
    chk("rst_l_gnt", l_gnt, 1'b0);
    chk("rst_m_en", m_en, 1'b0);
    chk("rst_m_we", m_we, 1'b0);
    chk("rst_f_rvalid", f_rvalid, 1'b0);
    chk("rst_l_rvalid", l_rvalid, 1'b0);
    chk("rst_halt_ack", halt_ack, 1'b0);
    f_req = 1'b0; l_req = 1'b0; l_we = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Conflict from reset: F, L, F, L
    for (int i = 0; i < 4; i++)
      drive(1, 32'(i * 4), 1, 0, 32'(32 + i * 4), 32'd0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);

    // Fetch-only stream of words 0, 1, 2
    drive(1, 32'h0, 0, 0, 0, 0, 0);
    chk("fetch_w0", f_rdata, 32'd0);
    drive(1, 32'h4, 0, 0, 0, 0, 0);
    chk("fetch_w1", f_rdata, 32'd1);
    drive(1, 32'h8, 0, 0, 0, 0, 0);
    chk("fetch_w2", f_rdata, 32'd2);

    // Halt while fetching, loader write/read, resume
    drive(1, 32'hC, 0, 0, 0, 0, 1);
    drive(1, 32'hC, 0, 0, 0, 0, 1);
    drive(1, 32'hC, 1, 1, 32'h10, 32'hDEADBEEF, 1);
    chk("halt_ack_held", halt_ack, 1'b1);
    drive(1, 32'hC, 1, 0, 32'h10, 32'd0, 1);
    chk("halt_rd", l_rdata, 32'hDEADBEEF);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 32'h10, 0, 0, 0, 0, 0);
    chk("resume_fetch", f_rdata, 32'hDEADBEEF);

    // Address errors; out-of-range write must leave word 0 intact
    drive(1, 32'h2, 0, 0, 0, 0, 0);
    chk("ferr", f_err, 1'b1);
    drive(0, 0, 1, 1, 32'h100, 32'h12345678, 0);
    chk("lerr", l_err, 1'b1);
    drive(0, 0, 1, 0, 32'h0, 0, 0);
    chk("ram_unchanged", l_rdata, 32'd0);

    // Random traffic
    hr = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) hr = !hr;
      drive(1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), rand_addr(), $urandom, hr);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);

    // Reset the cycle after a grant: response discarded, pointer restored
    drive(1, 32'h4, 1, 0, 32'h8, 0, 0);
    f_req = 1'b1; f_addr = 32'h4; l_req = 1'b0;
    #2;
    chk("pre_rst_gnt", f_gnt, 1'b1);
    @(posedge clk);
    #1 reset_n = 1'b0;
    f_req = 1'b0;
    #1;
    chk("rst_drop_fv", f_rvalid, 1'b0);
    chk("rst_drop_lv", l_rvalid, 1'b0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 32'h0, 1, 0, 32'h4, 0, 0);
    chk("post_rst_fetch_first", f_rvalid, 1'b1);
    drive(0, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_arb.md
IMEM_ARB -- requirements
Module: imem_arb

Interface
REQ-001 SHALL have parameter AW, default 6, meaning word-address width of the shared instruction RAM (2**AW words, 64 by default).
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state changes on rising edge.
REQ-003 SHALL have port reset_n, input, 1, meaning asynchronous active-low reset.
REQ-004 SHALL have port f_req, input, 1, meaning fetch read request.
REQ-005 SHALL have port f_addr, input, 32, meaning fetch byte address.
REQ-006 SHALL have port f_gnt, output, 1, meaning fetch request accepted this cycle.
REQ-007 SHALL have port f_rvalid / f_err, output, 1 each, meaning fetch response valid / response is an error.
REQ-008 SHALL have port f_rdata, output, 32, meaning fetch read data.
REQ-009 SHALL have port l_req / l_we, input, 1 each, meaning loader request / write (1) or read (0).
REQ-010 SHALL have port l_addr / l_wdata, input, 32 each, meaning loader byte address / write data.
REQ-011 SHALL have port l_gnt / l_rvalid / l_err, output, 1 each, meaning loader accept / response valid / error.
REQ-012 SHALL have port l_rdata, output, 32, meaning loader read data.
REQ-013 SHALL have port halt_req, input, 1, meaning loader requests exclusive RAM ownership (fetch blocked).
REQ-014 SHALL have port halt_ack, output, 1, meaning fetch drained, loader owns RAM.
REQ-015 SHALL have ports m_en, m_we (output, 1), m_addr (output, AW), m_wdata (output, 32), m_rdata (input, 32), meaning synchronous single-port RAM; m_rdata valid the cycle after m_en with m_we=0.

Function
REQ-016 SHALL implement FSM states RUN, DRAIN, HALTED; reset state RUN.
REQ-017 RUN: on f_req and l_req both high, SHALL grant round-robin (1-bit last-grant pointer, reset = loader-last so fetch wins first conflict); single requester granted immediately.
REQ-018 At most one of f_gnt, l_gnt SHALL be high per cycle; a grant drives m_en=1 in the same cycle with m_addr = addr[AW+1:2].
REQ-019 Read response SHALL appear exactly 1 cycle after grant: rvalid=1, rdata=m_rdata, to the granted requester only; back-to-back grants yield back-to-back responses.
REQ-020 Loader write (l_we=1) SHALL drive m_we=1, m_wdata=l_wdata, and return l_rvalid=1, l_rdata=0 one cycle later.
REQ-021 Address error: addr[1:0]!=0 or addr[31:AW+2]!=0 SHALL be granted with m_en=0 and return rvalid=1, err=1, rdata=0 one cycle later; RAM not written.
REQ-022 RUN with halt_req=1 SHALL move to DRAIN; fetch not granted from that cycle.
REQ-023 DRAIN SHALL move to HALTED once no fetch response is outstanding (at most 1 cycle).
REQ-024 HALTED: halt_ack=1; only loader granted; f_gnt=0 regardless of f_req.
REQ-025 HALTED with halt_req=0 SHALL return to RUN next cycle; halt_ack drops the same edge.
REQ-026 DRAIN with halt_req=0 SHALL return to RUN; loader may be granted in DRAIN and RUN.
REQ-027 Outputs f_rvalid, l_rvalid, f_err, l_err, f_rdata, l_rdata SHALL be registered; grants and m_* combinational from requests and state.
REQ-028 Requesters SHALL hold req/addr/wdata until gnt; arbiter SHALL NOT require that.

Reset
REQ-029 reset_n=0 SHALL asynchronously force state RUN, pointer loader-last, all rvalid/err=0, rdata=0, halt_ack=0; m_en, m_we, gnts=0 while reset asserted.
REQ-030 Reset mid-transaction SHALL discard any pending response; no rvalid after reset release without a new grant.

Verification
REQ-031 Fetch-only: f_req=1, addrs 0x0,0x4,0x8 consecutive cycles -> f_gnt every cycle, f_rvalid 1 cycle later each with RAM words 0,1,2.
REQ-032 Conflict: f_req=l_req=1 held 4 cycles -> grants F,L,F,L; each response on correct port, 1-cycle latency.
REQ-033 Halt: halt_req=1 while fetching -> f_gnt=0 next cycle, halt_ack=1 within 2 cycles; loader write 0xDEADBEEF to 0x10, then read 0x10 -> l_rdata=0xDEADBEEF; halt_req=0 -> RUN, fetch of 0x10 returns 0xDEADBEEF.
REQ-034 Errors: f_addr=0x2 -> f_err=1, f_rdata=0; l_we=1, l_addr=0x100 (AW=6) -> l_err=1, RAM unchanged.
REQ-035 Reset: assert reset_n=0 cycle after grant -> no rvalid after release; first conflict after reset grants fetch.
